n2r_feed_ctrl: RTL and testbench
================================

// Module: n2r_feed_ctrl
// PURPOSE
//  Sequencer for n2r_buffer_i. On start, reads ROW row-words from row memory (1-cycle read latency),
//  drives the buffer enable and row-valid qualifier, then counts slice_done pulses until the whole
//  matrix has left the buffer toward the NUM_CORES MAC cores. Reports done, or a timeout error.
// PARAMETERS
//  ROW         8    rows per matrix (rows fed to the buffer)
//  COL         6    elements per row
//  CHUNK_SIZE  4    elements per core chunk (BLOCK_SIZE^2)
//  NUM_CORES   2    cores served per output slice
//  ADDR_W      10   row-memory address width
//  TIMEOUT     64   max cycles between slice_done pulses while draining
//  NUM_SLICES  ROW*COL/(CHUNK_SIZE*NUM_CORES) (local, =6); expected slice_done pulses per matrix
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       synchronous active-low reset
//  start          in   1       start one matrix pass; ignored while busy=1
//  abort          in   1       synchronous abort; wins over all other inputs except rst_n
//  base_addr      in   ADDR_W  address of row 0; latched on accepted start
//  rd_en          out  1       row-memory read strobe
//  rd_addr        out  ADDR_W  row-memory address, base_addr + row index
//  buf_en         out  1       n2r_buffer_i en
//  buf_row_valid  out  1       high when memory read data on in_n2r_buffer is a valid row; datapath zeroes row otherwise
//  buf_slice_done in   1       slice_done pulse from n2r_buffer_i, one per output slice
//  slice_cnt      out  $clog2(NUM_SLICES+1)  slices seen in the current pass
//  busy           out  1       high from the cycle after an accepted start until DONE exits
//  done           out  1       1-cycle pulse when a pass ends, normally or on timeout
//  err_timeout    out  1       sticky; cleared by the next accepted start or by reset
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE. All outputs 0. Counters 0.
//  States: IDLE -> FEED -> DRAIN -> DONE -> IDLE.
//  IDLE: start=1 -> latch base_addr; clear slice_cnt, row_cnt, err_timeout; go FEED. Ignore buf_slice_done.
//  FEED: rd_en=1, rd_addr=base+row_cnt, row_cnt increments each cycle. When row_cnt=ROW-1, go DRAIN next.
//    rd_en is high for exactly ROW consecutive cycles.
//  buf_row_valid = rd_en delayed by 1 cycle; it is high for exactly ROW cycles.
//  buf_en rises with the first buf_row_valid. It stays high through FEED and DRAIN and falls on entry to DONE.
//  Timing: start accepted at edge 0 -> rd_en high cycles 1..ROW -> buf_row_valid high cycles 2..ROW+1.
//  slice_cnt increments on each buf_slice_done in FEED or DRAIN (these can overlap with FEED).
//    When the increment reaches NUM_SLICES, go DONE.
//    This check has priority over the FEED->DRAIN transition, but row feeding never ends early.
//    If the last slice arrives during FEED, the rd_en/buf_row_valid sequence still finishes before DONE.
//  DRAIN: idle counter resets on each buf_slice_done, otherwise increments.
//    Counter reaching TIMEOUT -> set err_timeout, go DONE.
//  DONE: lasts one cycle. done=1, busy=0 next cycle, return to IDLE.
//    slice_cnt holds its value until the next start.
//  abort in any non-IDLE state -> IDLE next cycle. rd_en, buf_en, buf_row_valid and busy drop that cycle.
//    done is not pulsed; slice_cnt holds.
//  start in the same cycle as DONE is ignored; start must be seen in IDLE.
//  rd_addr wraps modulo 2^ADDR_W.
//  Extra buf_slice_done pulses in IDLE/DONE are ignored and slice_cnt never exceeds NUM_SLICES.
//  All outputs are registered.
// TESTING
//  1. Defaults, base_addr=0, start.
//     -> rd_addr 0..7 on cycles 1..8; buf_row_valid cycles 2..9.
//     -> 6 slice_done pulses -> done pulse once, slice_cnt=6, err_timeout=0.
//  2. base_addr=2^ADDR_W-3.
//     -> rd_addr sequence ...FD,3FE,3FF,000..004, then completes normally.
//  3. Only 5 slice_done pulses, then silence.
//     -> after 64 idle DRAIN cycles: err_timeout=1 and done pulses.
//     -> next start clears err_timeout.
//  4. abort on cycle 4 of FEED.
//     -> next cycle rd_en=buf_en=busy=0 and no done pulse.
//     -> a fresh start then completes a full pass correctly.
//  5. start pulsed while busy, and slice_done pulsed in IDLE.
//     -> both ignored; pass count and addresses unchanged.
//  6. rst_n=0 mid-DRAIN.
//     -> all outputs 0 on the next edge; state IDLE; start works afterwards.

Source files
------------

// File: rtl/n2r_feed_ctrl.sv
// n2r_feed_ctrl: sequences row reads into n2r_buffer_i, then counts slice_done pulses until the matrix drains
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   start, abort, base_addr pass control; base_addr latched on accepted start
//   rd_en, rd_addr          row-memory read strobe and address (1-cycle read latency)
//   buf_en, buf_row_valid   buffer enable and row qualifier (rd_en delayed one cycle)
//   buf_slice_done          one pulse per output slice from the buffer
//   slice_cnt, busy, done   pass progress and status
//   err_timeout             sticky drain timeout flag
module n2r_feed_ctrl #(
  parameter int ROW        = 8,
  parameter int COL        = 6,
  parameter int CHUNK_SIZE = 4,
  parameter int NUM_CORES  = 2,
  parameter int ADDR_W     = 10,
  parameter int TIMEOUT    = 64,
  localparam int NUM_SLICES = ROW * COL / (CHUNK_SIZE * NUM_CORES),
  localparam int SC_W       = $clog2(NUM_SLICES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              buf_en,
  output logic              buf_row_valid,
  input  logic              buf_slice_done,
  output logic [SC_W-1:0]   slice_cnt,
  output logic              busy,
  output logic              done,
  output logic              err_timeout
);
  localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0]   ROW_LAST = RW'(ROW - 1);
  localparam logic [SC_W-1:0] NS_C     = SC_W'(NUM_SLICES);
  localparam logic [IW-1:0]   TO_C     = IW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  state_t            state_q, state_d;
  logic [RW-1:0]     row_cnt_q, row_cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [SC_W-1:0]   slice_cnt_q, slice_cnt_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic              rd_en_q, rd_en_d;
  logic              buf_en_q, buf_en_d;
  logic              row_valid_q, row_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              active, slice_inc;
  assign active    = (state_q == FEED) || (state_q == DRAIN);
  // Slices are only counted mid-pass, saturate at NUM_SLICES, and abort suppresses them.
  assign slice_inc = buf_slice_done && active && (slice_cnt_q != NS_C) && !abort;
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    rd_addr_d   = rd_addr_q;
    rd_en_d     = 1'b0;
    idle_d      = idle_q;
    err_d       = err_q;
    slice_cnt_d = slice_inc ? slice_cnt_q + 1'b1 : slice_cnt_q;
    case (state_q)
      IDLE: if (start && !abort) begin
        state_d     = FEED;
        rd_en_d     = 1'b1;
        rd_addr_d   = base_addr;
        row_cnt_d   = '0;
        slice_cnt_d = '0;
        err_d       = 1'b0;
      end
      FEED: if (row_cnt_q == ROW_LAST) begin
        state_d = DRAIN;
        idle_d  = '0;
      end else begin
        rd_en_d   = 1'b1;
        row_cnt_d = row_cnt_q + 1'b1;
        rd_addr_d = rd_addr_q + 1'b1;
      end
      DRAIN: begin
        idle_d = buf_slice_done ? '0 : idle_q + 1'b1;
        // A matrix completed during FEED finishes here, after the last row has been qualified.
        if (slice_cnt_d == NS_C) state_d = DONE;
        else if (idle_d == TO_C) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      rd_en_d = 1'b0;
    end
    busy_d      = state_d != IDLE;
    done_d      = state_d == DONE;
    row_valid_d = rd_en_q && !abort;
    buf_en_d    = ((state_d == FEED) || (state_d == DRAIN)) && (rd_en_q || buf_en_q);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      rd_addr_q   <= '0;
      slice_cnt_q <= '0;
      idle_q      <= '0;
      rd_en_q     <= 1'b0;
      buf_en_q    <= 1'b0;
      row_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      rd_addr_q   <= rd_addr_d;
      slice_cnt_q <= slice_cnt_d;
      idle_q      <= idle_d;
      rd_en_q     <= rd_en_d;
      buf_en_q    <= buf_en_d;
      row_valid_q <= row_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end
  assign rd_en         = rd_en_q;
  assign rd_addr       = rd_addr_q;
  assign buf_en        = buf_en_q;
  assign buf_row_valid = row_valid_q;
  assign slice_cnt     = slice_cnt_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_timeout   = err_q;
endmodule

// File: tb/tb_n2r_feed_ctrl.sv
// tb_n2r_feed_ctrl: directed checks of the n2r_feed_ctrl pass sequence, timeout, abort and reset
module tb_n2r_feed_ctrl;
  logic       clk, rst_n, start, abort, buf_slice_done;
  logic [9:0] base_addr, rd_addr;
  logic       rd_en, buf_en, buf_row_valid, busy, done, err_timeout;
  logic [2:0] slice_cnt;
  int n_tests = 0;
  int n_fail  = 0;
  n2r_feed_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .buf_en(buf_en), .buf_row_valid(buf_row_valid),
    .buf_slice_done(buf_slice_done), .slice_cnt(slice_cnt), .busy(busy), .done(done),
    .err_timeout(err_timeout)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [9:0] b);
    base_addr = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; abort = 1'b0; buf_slice_done = 1'b1; base_addr = 10'h3ff;
    tick(); tick();
    n_tests++; if ({rd_en, rd_addr, buf_en, buf_row_valid, slice_cnt, busy, done, err_timeout} !== '0) begin n_fail++; $display("FAIL reset_outputs got %b exp 0", {rd_en, rd_addr, buf_en, buf_row_valid, slice_cnt, busy, done, err_timeout}); end
    start = 1'b0; buf_slice_done = 1'b0; rst_n = 1'b1;
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle busy got %b exp 0", busy); end
  endtask
  task automatic test_full_pass(input logic [9:0] b);
    logic [9:0] ea;
    go(b);
    for (int c = 1; c <= 10; c++) begin
      ea = b + 10'(c - 1);
      n_tests++; if (rd_en !== (c <= 8)) begin n_fail++; $display("FAIL pass_rd_en c=%0d got %b exp %b", c, rd_en, c <= 8); end
      if (c <= 8) begin n_tests++; if (rd_addr !== ea) begin n_fail++; $display("FAIL pass_rd_addr c=%0d got %h exp %h", c, rd_addr, ea); end end
      n_tests++; if (buf_row_valid !== (c >= 2 && c <= 9)) begin n_fail++; $display("FAIL pass_row_valid c=%0d got %b", c, buf_row_valid); end
      n_tests++; if (buf_en !== (c >= 2)) begin n_fail++; $display("FAIL pass_buf_en c=%0d got %b", c, buf_en); end
      n_tests++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL pass_busy_done c=%0d got %b exp 10", c, {busy, done}); end
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      buf_slice_done = 1'b1;
      tick();
      buf_slice_done = 1'b0;
      n_tests++; if (slice_cnt !== 3'(k + 1)) begin n_fail++; $display("FAIL pass_slice_cnt k=%0d got %0d exp %0d", k, slice_cnt, k + 1); end
      n_tests++; if (done !== (k == 5)) begin n_fail++; $display("FAIL pass_done k=%0d got %b exp %b", k, done, k == 5); end
      n_tests++; if (buf_en !== (k != 5)) begin n_fail++; $display("FAIL pass_drain_buf_en k=%0d got %b", k, buf_en); end
      if (k < 5) tick();
    end
    n_tests++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL pass_err got %b exp 0", err_timeout); end
    tick();
    n_tests++; if ({busy, done, buf_en, slice_cnt} !== {3'b000, 3'd6}) begin n_fail++; $display("FAIL pass_end got busy/done/en/cnt %b exp 000110", {busy, done, buf_en, slice_cnt}); end
  endtask
  task automatic test_overlap();
    logic [2:0] es;
    go(10'h000);
    for (int c = 1; c <= 11; c++) begin
      es = 3'((c - 1 > 6) ? 6 : c - 1);
      n_tests++; if (rd_en !== (c <= 8)) begin n_fail++; $display("FAIL ovl_rd_en c=%0d got %b", c, rd_en); end
      n_tests++; if (buf_row_valid !== (c >= 2 && c <= 9)) begin n_fail++; $display("FAIL ovl_row_valid c=%0d got %b", c, buf_row_valid); end
      n_tests++; if (buf_en !== (c >= 2 && c <= 9)) begin n_fail++; $display("FAIL ovl_buf_en c=%0d got %b", c, buf_en); end
      n_tests++; if (slice_cnt !== es) begin n_fail++; $display("FAIL ovl_slice_cnt c=%0d got %0d exp %0d", c, slice_cnt, es); end
      n_tests++; if (done !== (c == 10)) begin n_fail++; $display("FAIL ovl_done c=%0d got %b exp %b", c, done, c == 10); end
      n_tests++; if (busy !== (c <= 10)) begin n_fail++; $display("FAIL ovl_busy c=%0d got %b", c, busy); end
      buf_slice_done = (c <= 7);
      tick();
    end
    buf_slice_done = 1'b0;
  endtask
  task automatic test_timeout();
    int first_done = 0;
    logic err_before = 1'b1;
    go(10'h000);
    for (int c = 1; c <= 90 && first_done == 0; c++) begin
      if (done) first_done = c;
      else begin
        err_before = err_timeout;
        buf_slice_done = (c <= 5);
        tick();
      end
    end
    buf_slice_done = 1'b0;
    n_tests++; if (first_done != 73) begin n_fail++; $display("FAIL to_done_cycle got %0d exp 73", first_done); end
    n_tests++; if (err_before !== 1'b0) begin n_fail++; $display("FAIL to_err_early got %b exp 0", err_before); end
    n_tests++; if ({err_timeout, slice_cnt} !== {1'b1, 3'd5}) begin n_fail++; $display("FAIL to_err_cnt got %b exp 1101", {err_timeout, slice_cnt}); end
    tick();
    n_tests++; if ({busy, done, err_timeout} !== 3'b001) begin n_fail++; $display("FAIL to_sticky got %b exp 001", {busy, done, err_timeout}); end
    go(10'h000);
    n_tests++; if ({busy, err_timeout} !== 2'b10) begin n_fail++; $display("FAIL to_clear got %b exp 10", {busy, err_timeout}); end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask
  task automatic test_abort();
    go(10'h000);
    tick(); tick(); tick();
    n_tests++; if ({rd_en, buf_en, busy} !== 3'b111) begin n_fail++; $display("FAIL abort_pre got %b exp 111", {rd_en, buf_en, busy}); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_tests++; if ({rd_en, buf_en, buf_row_valid, busy, done} !== 5'b0) begin n_fail++; $display("FAIL abort_drop got %b exp 00000", {rd_en, buf_en, buf_row_valid, busy, done}); end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_tests++; if ({busy, done, rd_en} !== 3'b000) begin n_fail++; $display("FAIL abort_quiet c=%0d got %b exp 000", c, {busy, done, rd_en}); end
    end
  endtask
  task automatic test_ignore();
    logic [9:0] ea;
    for (int c = 0; c < 3; c++) begin
      buf_slice_done = 1'b1;
      tick();
    end
    buf_slice_done = 1'b0;
    n_tests++; if ({busy, slice_cnt} !== {1'b0, 3'd6}) begin n_fail++; $display("FAIL ign_idle_slice got %b exp 0110", {busy, slice_cnt}); end
    go(10'h020);
    for (int c = 1; c <= 8; c++) begin
      ea = 10'h020 + 10'(c - 1);
      n_tests++; if ({rd_en, rd_addr} !== {1'b1, ea}) begin n_fail++; $display("FAIL ign_addr c=%0d got %h exp %h", c, rd_addr, ea); end
      start = (c == 3);
      base_addr = 10'h100;
      tick();
    end
    start = 1'b0;
    n_tests++; if ({rd_en, busy} !== 2'b01) begin n_fail++; $display("FAIL ign_feed_end got %b exp 01", {rd_en, busy}); end
    for (int k = 0; k < 6; k++) begin
      tick();
      buf_slice_done = 1'b1;
      tick();
      buf_slice_done = 1'b0;
    end
    n_tests++; if ({done, slice_cnt} !== {1'b1, 3'd6}) begin n_fail++; $display("FAIL ign_done got %b exp 1110", {done, slice_cnt}); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++; if ({busy, rd_en, done} !== 3'b000) begin n_fail++; $display("FAIL ign_start_in_done got %b exp 000", {busy, rd_en, done}); end
    tick();
    n_tests++; if ({busy, rd_en} !== 2'b00) begin n_fail++; $display("FAIL ign_stay_idle got %b exp 00", {busy, rd_en}); end
  endtask
  task automatic test_reset_mid();
    go(10'h000);
    for (int c = 1; c <= 9; c++) tick();
    buf_slice_done = 1'b1;
    tick();
    buf_slice_done = 1'b0;
    n_tests++; if ({busy, buf_en, slice_cnt} !== {2'b11, 3'd1}) begin n_fail++; $display("FAIL rmid_pre got %b exp 11001", {busy, buf_en, slice_cnt}); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_tests++; if ({rd_en, rd_addr, buf_en, buf_row_valid, slice_cnt, busy, done, err_timeout} !== '0) begin n_fail++; $display("FAIL rmid_outputs got %b exp 0", {rd_en, rd_addr, buf_en, buf_row_valid, slice_cnt, busy, done, err_timeout}); end
  endtask
  initial begin
    test_reset();
    test_full_pass(10'h000);
    test_full_pass(10'h3fd);
    test_overlap();
    test_timeout();
    test_abort();
    test_full_pass(10'h010);
    test_ignore();
    test_reset_mid();
    test_full_pass(10'h055);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
endmodule
